instr_encoder_loader: RTL and testbench

- Inverse of the instruction decoder: accepts abstract instruction descriptors (kind, rs, rt, rd, imm) over a valid/ready handshake.
- Encodes each descriptor into a 32-bit MIPS word (R-type add/sub/and/or/slt/nor, lw, sw, beq).
- Writes the words sequentially into instruction memory, starting at address 0.
- Used by the bench/boot path to load programs before the single-cycle core runs.

---
 rtl/instr_encoder_loader.sv | 120 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Boot-path program loader: encodes abstract instruction descriptors into MIPS
// words and writes them sequentially into instruction memory from address 0.
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              loading,
    output logic              done,
    output logic              err_illegal
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    // Handshake: a descriptor transfers on a cycle where in_valid && in_ready;
    // in_valid may be held, in_ready never depends on in_valid.
    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   issue_cnt;
    logic              accept;
    logic              legal;
    logic [31:0]       enc;

    assign in_ready = (state == S_LOAD) && !start && (issue_cnt < DEPTH_CNT);
    assign accept   = in_valid && in_ready;
    assign legal    = (kind <= 4'd8);
    assign loading  = (state == S_LOAD);
    assign done     = (state == S_DONE) && !imem_we;

    always_comb begin
        enc = 32'd0;
        case (kind)
            4'd0: enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
            4'd1: enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
            4'd2: enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
            4'd3: enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
            4'd4: enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
            4'd5: enc = {6'b000000, rs, rt, rd, 5'b00000, 6'b100111};
            4'd6: enc = {6'b100011, rs, rt, imm};
            4'd7: enc = {6'b101011, rs, rt, imm};
            4'd8: enc = {6'b000100, rs, rt, imm};
            default: enc = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (start)
                    state_next = S_LOAD;
                else if (finish || (accept && legal && (issue_cnt == DEPTH_CNT - CNT_ONE)))
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (start) state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            issue_cnt   <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= 32'd0;
            word_count  <= '0;
            err_illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                // Restart discards any write still in flight.
                issue_cnt   <= '0;
                imem_we     <= 1'b0;
                word_count  <= '0;
                err_illegal <= 1'b0;
            end else begin
                imem_we <= accept && legal;
                if (imem_we)
                    word_count <= word_count + CNT_ONE;
                // Address comes from the issue count, so back-to-back writes
                // land on consecutive words even while word_count lags by one.
                if (accept && legal) begin
                    issue_cnt  <= issue_cnt + CNT_ONE;
                    imem_addr  <= issue_cnt[ADDR_W-1:0];
                    imem_wdata <= enc;
                end
                if (accept && !legal)
                    err_illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized bench for instr_encoder_loader (ADDR_W=2) against a
// cycle-level behavioural model with an expected-write queue.
module tb_instr_encoder_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          finish;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    kind;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [15:0]   imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          loading;
    logic          done;
    logic          err_illegal;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .kind       (kind),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .loading    (loading),
        .done       (done),
        .err_illegal(err_illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and model state
    int total;
    int bad;
    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] last_wr;
    int m_mode;   // 0 idle, 1 loading, 2 done
    int m_cnt;
    int m_words;
    bit m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input int k, input int s, input int t,
                                           input int d, input int i);
        int funct_tab[6];
        int op_tab[3];
        logic [31:0] w;
        funct_tab = '{32, 34, 36, 37, 42, 39};
        op_tab    = '{35, 43, 4};
        if (k < 6)
            w = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(funct_tab[k]);
        else
            w = (32'(op_tab[k-6]) << 26) | (32'(s) << 21) | (32'(t) << 16) | (32'(i) & 32'hFFFF);
        return w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        last_wr = '0;
        m_mode  = 0;
        m_cnt   = 0;
        m_words = 0;
        m_err   = 0;
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the model.
    task automatic step(input bit st, input bit fin, input bit v, input int k,
                        input int s, input int t, input int d, input int i);
        bit exp_ready;
        bit exp_we;
        bit acc;
        @(negedge clk);
        start    = st;
        finish   = fin;
        in_valid = v;
        kind     = 4'(k);
        rs       = 5'(s);
        rt       = 5'(t);
        rd       = 5'(d);
        imm      = 16'(i);
        #1;
        exp_ready = (m_mode == 1) && !st && (m_cnt < DEPTH);
        exp_we    = (exp_q.size() != 0);
        if (exp_we) last_wr = exp_q.pop_front();
        chk("in_ready", in_ready, exp_ready);
        chk("imem_we", imem_we, exp_we);
        chk("imem_addr", imem_addr, last_wr[AW+31:32]);
        chk("imem_wdata", imem_wdata, last_wr[31:0]);
        chk("word_count", word_count, m_words);
        chk("loading", loading, m_mode == 1);
        chk("done", done, (m_mode == 2) && !exp_we);
        chk("err_illegal", err_illegal, m_err);
        acc = v && exp_ready;
        if (exp_we) m_words++;
        if (acc && k <= 8) begin
            exp_q.push_back({AW'(m_cnt), encode(k, s, t, d, i)});
            m_cnt++;
        end
        if (acc && k > 8) m_err = 1;
        if (st) begin
            m_mode  = 1;
            m_cnt   = 0;
            m_words = 0;
            m_err   = 0;
            exp_q.delete();
        end else if (m_mode == 1 && (fin || m_cnt == DEPTH)) begin
            m_mode = 2;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"}, imem_we, 1'b0);
        chk({tag, "_addr"}, imem_addr, '0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_count"}, word_count, '0);
        chk({tag, "_loading"}, loading, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err_illegal, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n = 1'b0;
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; imm = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // add r3, r1, r2
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 2, 3, 0);
        idle();
        chk("t1_addr", imem_addr, 2'd0);
        chk("t1_wdata", imem_wdata, 32'h00221820);
        idle();
        chk("t1_count", word_count, 3'd1);

        // lw / sw / beq back to back
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 6, 29, 8, 0, 16'h0004);
        step(0, 0, 1, 7, 29, 9, 0, 16'hFFFC);
        chk("t2_lw", {imem_we, imem_addr, imem_wdata}, {1'b1, 2'd0, 32'h8FA80004});
        step(0, 0, 1, 8, 8, 9, 0, 16'h0002);
        chk("t2_sw", {imem_we, imem_addr, imem_wdata}, {1'b1, 2'd1, 32'hAFA9FFFC});
        idle();
        chk("t2_beq", {imem_we, imem_addr, imem_wdata}, {1'b1, 2'd2, 32'h11090002});
        idle();

        // fill all four words, then keep offering a fifth
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4; n++) step(0, 0, 1, n, n, n + 1, n + 2, 0);
        step(0, 0, 1, 1, 7, 7, 7, 0);
        chk("t3_ready_low", in_ready, 1'b0);
        chk("t3_done_pending", done, 1'b0);
        chk("t3_last_addr", imem_addr, 2'd3);
        step(0, 0, 1, 1, 7, 7, 7, 0);
        chk("t3_done", done, 1'b1);
        chk("t3_count", word_count, 3'd4);
        chk("t3_no_fifth", imem_we, 1'b0);

        // illegal kind between two adds
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 4, 5, 6, 0);
        step(0, 0, 1, 12, 1, 1, 1, 0);
        step(0, 0, 1, 0, 7, 8, 9, 0);
        chk("t4_err", err_illegal, 1'b1);
        chk("t4_no_write", imem_we, 1'b0);
        idle();
        chk("t4_addr1", imem_addr, 2'd1);
        idle();
        chk("t4_count", word_count, 3'd2);

        // slt accepted together with finish
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 4, 10, 11, 12, 0);
        idle();
        chk("t5_funct", imem_wdata[5:0], 6'h2A);
        chk("t5_loading", loading, 1'b0);
        idle();
        chk("t5_done", done, 1'b1);
        step(0, 1, 1, 0, 1, 1, 1, 0);
        idle();
        chk("t5_still_done", done, 1'b1);

        // restart while a write is pending, then reset mid-load
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 13, 0, 0, 0, 0);
        step(0, 0, 1, 2, 3, 4, 5, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("t6_we", imem_we, 1'b0);
        chk("t6_count", word_count, 3'd0);
        chk("t6_err", err_illegal, 1'b0);
        step(0, 0, 1, 3, 1, 2, 3, 0);
        mid_reset();
        idle();
        idle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0)
                mid_reset();
            else
                step($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 11),
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 65535));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
